fsm_ctx_arbiter: RTL and testbench
==================================

Name: fsm_ctx_arbiter

Overview:
- Shares one 6-state Moore sequence-FSM next-state/output datapath among NREQ requesters.
- Each requester owns a private 3-bit context (state) register.
- A round-robin arbiter grants one 2-bit symbol per cycle. The shared logic advances that requester's context, and the result is returned through a one-entry registered response port with a val/rdy handshake.
- Sits between several symbol-stream producers and a single downstream consumer of per-stream detector outputs.

Parameters:
- NREQ, 4, number of requesters/contexts (2..8)
- IDW, $clog2(NREQ), width of requester id

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low; reset==0 clears all state immediately
- req_val  input  NREQ  per-requester symbol valid
- req_sym  input  2*NREQ  symbol for requester i in bits [2i+1:2i]
- req_rdy  output  NREQ  one-hot (or zero) grant; symbol i accepted when req_val[i] && req_rdy[i]
- resp_val  output  1  response valid
- resp_rdy  input  1  downstream ready
- resp_id  output  IDW  requester whose symbol produced this response
- resp_state  output  3  context state after the update
- resp_out  output  2  Moore output of resp_state

Behaviour:
- State encoding: A=0, B=1, C=2, D=3, E=4, F=5. Contexts 6/7 are illegal: next state = A, output = 00.
- Next state, by current state, listed for sym 00 / 01 / 10 / 11:
  - A: A / B / A / E
  - B: C / B / A / E
  - C: A / D / A / E
  - D: C / B / A / E
  - E: F / F / A / E
  - F: A / A / A / A
- Moore output: A, B, C -> 00; D -> 01; E, F -> 10.
- Reset (async, reset==0):
  - all contexts = A
  - rr pointer = 0
  - resp_val = 0; resp_id, resp_state, resp_out = 0
  - req_rdy = 0 while reset is asserted
- Accept condition: can_accept = !resp_val || resp_rdy.
- Grant (combinational):
  - If can_accept, grant the first i with req_val[i]=1, searching from rr pointer upward and wrapping modulo NREQ.
  - req_rdy is one-hot on that i, else all zero.
  - req_rdy never depends on req_val of the same index in any way other than this search.
- On a grant to i at posedge:
  - ctx[i] <= next(ctx[i], sym_i)
  - resp_val <= 1; resp_id <= i
  - resp_state <= next(ctx[i], sym_i); resp_out <= moore(resp_state)
  - rr pointer <= (i+1) mod NREQ
- Latency: 1 cycle from accept to resp_val.
- Throughput: 1 symbol/cycle while resp_rdy is held high.
- No grant and (resp_val && resp_rdy): resp_val <= 0. rr pointer and contexts unchanged.
- Back-pressure: resp_val && !resp_rdy gives req_rdy = 0 and the response registers hold stable. Pending requests are not lost; requesters hold val.
- Simultaneous drain and accept in the same cycle is legal, with no bubble.
- Contexts of non-granted requesters never change.
- Only one context is written per cycle.
- Mid-operation reset discards any in-flight response and all context history.

Optional Feature:
- Macro: FSM_CTX_ARBITER_CLEAR_EN.
- Defined:
  - Adds input port ctx_clear [NREQ].
  - ctx_clear[i]=1 forces req_rdy[i]=0 and sets ctx[i] <= A at the next posedge.
  - The arbiter skips i that cycle and does not advance the rr pointer on its account.
  - Other requesters are granted normally.
  - A response already held in the output register is unaffected.
- Undefined:
  - Port absent.
  - Contexts return to A only via reset or via the FSM table.

Test Plan:
- Reset, then requester 0 sends 01, 00, 01 back-to-back with resp_rdy=1 -> responses (id 0): B/00, C/00, D/01 on consecutive cycles.
- Requester 1 sends 11, 00, 00 -> E/10, F/10, A/00. Then requester 1 sends 11 and requester 2 sends 10 in one request cycle -> ctx[1]=E, ctx[2]=A, each context independent.
- All four req_val=1 continuously, resp_rdy=1 -> grant order 0,1,2,3,0,... One response per cycle, ids matching.
- resp_rdy=0 for 3 cycles with req_val[0]=1 -> req_rdy=0, resp_* stable, ctx[0] unchanged. Raise resp_rdy -> accept resumes the same cycle with no bubble.
- Assert reset low asynchronously mid-stream with resp_val=1 -> resp_val drops immediately, all contexts read A afterwards (first response on sym 01 = B/00).
- With FSM_CTX_ARBITER_CLEAR_EN: drive ctx[3] to D, pulse ctx_clear[3] while req_val[3]=1 -> no grant to 3 that cycle. Next sym 01 -> B/00.

Source files
------------

// File: rtl/fsm_ctx_arbiter.sv
// fsm_ctx_arbiter: NREQ per-requester contexts time-share one 6-state Moore sequence FSM
// behind a round-robin arbiter and a one-entry response register. Optional macro: FSM_CTX_ARBITER_CLEAR_EN.
module fsm_ctx_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    input  logic [2*NREQ-1:0] req_sym,
    output logic [NREQ-1:0]   req_rdy,
`ifdef FSM_CTX_ARBITER_CLEAR_EN
    input  logic [NREQ-1:0]   ctx_clear,
`endif
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [IDW-1:0]    resp_id,
    output logic [2:0]        resp_state,
    output logic [1:0]        resp_out,
    output logic [3*NREQ-1:0] dbg_ctx
);

    localparam int IW1 = IDW + 1;

    localparam logic [2:0] ST_A = 3'd0;
    localparam logic [2:0] ST_B = 3'd1;
    localparam logic [2:0] ST_C = 3'd2;
    localparam logic [2:0] ST_D = 3'd3;
    localparam logic [2:0] ST_E = 3'd4;
    localparam logic [2:0] ST_F = 3'd5;

    // Handshake: a symbol moves when req_val[i] && req_rdy[i]; a response moves when
    // resp_val && resp_rdy. Producers must hold val/data until accepted.

    function automatic logic [2:0] fsm_next(input logic [2:0] st, input logic [1:0] sym);
        logic [2:0] nx;
        nx = ST_A;
        case (st)
            ST_A: case (sym) 2'b00: nx = ST_A; 2'b01: nx = ST_B; 2'b10: nx = ST_A; default: nx = ST_E; endcase
            ST_B: case (sym) 2'b00: nx = ST_C; 2'b01: nx = ST_B; 2'b10: nx = ST_A; default: nx = ST_E; endcase
            ST_C: case (sym) 2'b00: nx = ST_A; 2'b01: nx = ST_D; 2'b10: nx = ST_A; default: nx = ST_E; endcase
            ST_D: case (sym) 2'b00: nx = ST_C; 2'b01: nx = ST_B; 2'b10: nx = ST_A; default: nx = ST_E; endcase
            ST_E: case (sym) 2'b00: nx = ST_F; 2'b01: nx = ST_F; 2'b10: nx = ST_A; default: nx = ST_E; endcase
            ST_F: nx = ST_A;
            default: nx = ST_A;  // 6/7 are unreachable; recover to A
        endcase
        return nx;
    endfunction

    function automatic logic [1:0] fsm_moore(input logic [2:0] st);
        logic [1:0] o;
        case (st)
            ST_D:       o = 2'b01;
            ST_E, ST_F: o = 2'b10;
            default:    o = 2'b00;
        endcase
        return o;
    endfunction

    // Modulo-NREQ add that also works when NREQ is not a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
        logic [IDW:0] s;
        s = {1'b0, base} + IW1'(off);
        if (s >= IW1'(NREQ)) begin
            s = s - IW1'(NREQ);
        end
        return s[IDW-1:0];
    endfunction

    logic [2:0]      ctx_q [NREQ];
    logic [2:0]      ctx_d [NREQ];
    logic [IDW-1:0]  rr_q, rr_d;
    logic            resp_val_q, resp_val_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [2:0]      resp_state_q, resp_state_d;
    logic [1:0]      resp_out_q, resp_out_d;

    logic            can_accept;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] elig;
    logic [1:0]      gnt_sym;
    logic [2:0]      gnt_cur;
    logic [2:0]      gnt_next;

    // Arbitration: first eligible requester at or after rr_q, only while not in reset.
    always_comb begin
`ifdef FSM_CTX_ARBITER_CLEAR_EN
        elig = req_val & ~ctx_clear;
`else
        elig = req_val;
`endif
        can_accept = !resp_val_q || resp_rdy;
        gnt_found  = 1'b0;
        gnt_id     = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(rr_q, k);
            if (reset && can_accept && !gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        gnt_sym = 2'b00;
        gnt_cur = ST_A;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_id) begin
                gnt_sym = req_sym[2*i +: 2];
                gnt_cur = ctx_q[i];
            end
        end
        gnt_next = fsm_next(gnt_cur, gnt_sym);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                ctx_q[i] <= ST_A;
            end
            rr_q         <= '0;
            resp_val_q   <= 1'b0;
            resp_id_q    <= '0;
            resp_state_q <= ST_A;
            resp_out_q   <= 2'b00;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            rr_q         <= rr_d;
            resp_val_q   <= resp_val_d;
            resp_id_q    <= resp_id_d;
            resp_state_q <= resp_state_d;
            resp_out_q   <= resp_out_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ctx_d[i] = ctx_q[i];
        end
        rr_d         = rr_q;
        resp_val_d   = resp_val_q;
        resp_id_d    = resp_id_q;
        resp_state_d = resp_state_q;
        resp_out_d   = resp_out_q;
        if (gnt_found) begin
            for (int i = 0; i < NREQ; i++) begin
                if (IDW'(i) == gnt_id) begin
                    ctx_d[i] = gnt_next;
                end
            end
            rr_d         = wrap_add(gnt_id, 1);
            resp_val_d   = 1'b1;
            resp_id_d    = gnt_id;
            resp_state_d = gnt_next;
            resp_out_d   = fsm_moore(gnt_next);
        end else if (resp_val_q && resp_rdy) begin
            resp_val_d = 1'b0;
        end
`ifdef FSM_CTX_ARBITER_CLEAR_EN
        // A cleared requester is never granted, so this cannot collide with the grant write.
        for (int i = 0; i < NREQ; i++) begin
            if (ctx_clear[i]) begin
                ctx_d[i] = ST_A;
            end
        end
`endif
    end

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_found && (IDW'(i) == gnt_id)) begin
                req_rdy[i] = 1'b1;
            end
        end
        resp_val   = resp_val_q;
        resp_id    = resp_id_q;
        resp_state = resp_state_q;
        resp_out   = resp_out_q;
        dbg_ctx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            dbg_ctx[3*i +: 3] = ctx_q[i];
        end
    end

endmodule

// File: tb/tb_fsm_ctx_arbiter.sv
// Directed bench for fsm_ctx_arbiter (NREQ=4); clear scenario built when FSM_CTX_ARBITER_CLEAR_EN is defined.
module tb_fsm_ctx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_val;
    logic [2*NREQ-1:0] req_sym;
    logic [NREQ-1:0]   req_rdy;
    logic              resp_val;
    logic              resp_rdy;
    logic [IDW-1:0]    resp_id;
    logic [2:0]        resp_state;
    logic [1:0]        resp_out;
    logic [3*NREQ-1:0] dbg_ctx;
`ifdef FSM_CTX_ARBITER_CLEAR_EN
    logic [NREQ-1:0]   ctx_clear;
`endif
    logic [7:0]        resp_w;

    int total = 0;
    int bad   = 0;

    assign resp_w = {resp_val, resp_id, resp_state, resp_out};

    always #5 clk = ~clk;

    fsm_ctx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_sym    (req_sym),
        .req_rdy    (req_rdy),
`ifdef FSM_CTX_ARBITER_CLEAR_EN
        .ctx_clear  (ctx_clear),
`endif
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_id    (resp_id),
        .resp_state (resp_state),
        .resp_out   (resp_out),
        .dbg_ctx    (dbg_ctx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req_val  = '0;
        req_sym  = '0;
        resp_rdy = 1'b1;
`ifdef FSM_CTX_ARBITER_CLEAR_EN
        ctx_clear = '0;
`endif
        #2;
        reset   = 1'b0;
        req_val = 4'b1111;
        #1;
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        total++; if (resp_w !== 8'h00) begin bad++; $display("FAIL reset_resp got=%h exp=%h", resp_w, 8'h00); end
        total++; if (dbg_ctx !== 12'h000) begin bad++; $display("FAIL reset_ctx got=%h exp=%h", dbg_ctx, 12'h000); end
        req_val = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", resp_val); end
    endtask

    task automatic test_sequence_r0();
        req_val = 4'b0001;
        req_sym = 8'b00_00_00_01;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL seq_rdy got=%b exp=%b", req_rdy, 4'b0001); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd1, 2'b00}) begin bad++; $display("FAIL seq_b got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd1, 2'b00}); end
        req_sym[1:0] = 2'b00;
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd2, 2'b00}) begin bad++; $display("FAIL seq_c got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd2, 2'b00}); end
        req_sym[1:0] = 2'b01;
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd3, 2'b01}) begin bad++; $display("FAIL seq_d got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd3, 2'b01}); end
        req_val = '0;
        tick();
        total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL seq_drain got=%b exp=0", resp_val); end
    endtask

    task automatic test_ctx_independent();
        req_val = 4'b0010;
        req_sym = 8'b00_00_11_00;
        tick();
        total++; if (resp_w !== {1'b1, 2'd1, 3'd4, 2'b10}) begin bad++; $display("FAIL r1_e got=%h exp=%h", resp_w, {1'b1, 2'd1, 3'd4, 2'b10}); end
        req_sym = 8'b00_00_00_00;
        tick();
        total++; if (resp_w !== {1'b1, 2'd1, 3'd5, 2'b10}) begin bad++; $display("FAIL r1_f got=%h exp=%h", resp_w, {1'b1, 2'd1, 3'd5, 2'b10}); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd1, 3'd0, 2'b00}) begin bad++; $display("FAIL r1_a got=%h exp=%h", resp_w, {1'b1, 2'd1, 3'd0, 2'b00}); end
        // rr now points at 2, so requester 2 wins first
        req_val = 4'b0110;
        req_sym = 8'b00_10_11_00;
        #1;
        total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL pair_rdy2 got=%b exp=%b", req_rdy, 4'b0100); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd2, 3'd0, 2'b00}) begin bad++; $display("FAIL pair_r2 got=%h exp=%h", resp_w, {1'b1, 2'd2, 3'd0, 2'b00}); end
        req_val = 4'b0010;
        #1;
        total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL pair_rdy1 got=%b exp=%b", req_rdy, 4'b0010); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd1, 3'd4, 2'b10}) begin bad++; $display("FAIL pair_r1 got=%h exp=%h", resp_w, {1'b1, 2'd1, 3'd4, 2'b10}); end
        req_val = '0;
        tick();
        total++; if (dbg_ctx !== {3'd0, 3'd0, 3'd4, 3'd3}) begin bad++; $display("FAIL ctx_snapshot got=%h exp=%h", dbg_ctx, {3'd0, 3'd0, 3'd4, 3'd3}); end
    endtask

    task automatic test_round_robin();
        int exp_id [8]    = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_state [8] = '{1, 4, 0, 0, 1, 4, 0, 0};
        int exp_out [8]   = '{0, 2, 0, 0, 0, 2, 0, 0};
        logic [7:0] exp_w;
        logic [3:0] exp_rdy;
        reset = 1'b0;
        #2;
        reset   = 1'b1;
        req_val = 4'b1111;
        req_sym = 8'b10_00_11_01;
        for (int n = 0; n < 8; n++) begin
            exp_rdy = 4'b0001 << exp_id[n];
            exp_w   = {1'b1, 2'(exp_id[n]), 3'(exp_state[n]), 2'(exp_out[n])};
            #1;
            total++; if (req_rdy !== exp_rdy) begin bad++; $display("FAIL rr_rdy[%0d] got=%b exp=%b", n, req_rdy, exp_rdy); end
            tick();
            total++; if (resp_w !== exp_w) begin bad++; $display("FAIL rr_resp[%0d] got=%h exp=%h", n, resp_w, exp_w); end
        end
    endtask

    task automatic test_back_pressure();
        resp_rdy = 1'b0;
        req_val  = 4'b0001;
        req_sym  = 8'b00_00_00_00;
        #1;
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL bp_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        for (int n = 0; n < 3; n++) begin
            tick();
            total++; if (resp_w !== {1'b1, 2'd3, 3'd0, 2'b00}) begin bad++; $display("FAIL bp_hold[%0d] got=%h exp=%h", n, resp_w, {1'b1, 2'd3, 3'd0, 2'b00}); end
            total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL bp_stall[%0d] got=%b exp=%b", n, req_rdy, 4'b0000); end
            total++; if (dbg_ctx[2:0] !== 3'd1) begin bad++; $display("FAIL bp_ctx0[%0d] got=%0d exp=1", n, dbg_ctx[2:0]); end
        end
        resp_rdy = 1'b1;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL bp_resume_rdy got=%b exp=%b", req_rdy, 4'b0001); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd2, 2'b00}) begin bad++; $display("FAIL bp_resume got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd2, 2'b00}); end
    endtask

    task automatic test_async_reset();
        req_sym[1:0] = 2'b01;
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd3, 2'b01}) begin bad++; $display("FAIL pre_reset got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd3, 2'b01}); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (resp_w !== 8'h00) begin bad++; $display("FAIL async_resp got=%h exp=%h", resp_w, 8'h00); end
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL async_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        total++; if (dbg_ctx !== 12'h000) begin bad++; $display("FAIL async_ctx got=%h exp=%h", dbg_ctx, 12'h000); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL post_reset_rdy got=%b exp=%b", req_rdy, 4'b0001); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd1, 2'b00}) begin bad++; $display("FAIL post_reset got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd1, 2'b00}); end
        req_val = '0;
        tick();
    endtask

`ifdef FSM_CTX_ARBITER_CLEAR_EN
    task automatic test_clear();
        logic [1:0] syms [3] = '{2'b01, 2'b00, 2'b01};
        req_val = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            req_sym = {syms[n], 6'b000000};
            tick();
        end
        total++; if (resp_w !== {1'b1, 2'd3, 3'd3, 2'b01}) begin bad++; $display("FAIL clr_setup got=%h exp=%h", resp_w, {1'b1, 2'd3, 3'd3, 2'b01}); end
        ctx_clear = 4'b1000;
        req_val   = 4'b1001;
        req_sym   = 8'b01_00_00_00;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL clr_rdy got=%b exp=%b", req_rdy, 4'b0001); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd0, 3'd2, 2'b00}) begin bad++; $display("FAIL clr_other got=%h exp=%h", resp_w, {1'b1, 2'd0, 3'd2, 2'b00}); end
        total++; if (dbg_ctx[11:9] !== 3'd0) begin bad++; $display("FAIL clr_ctx3 got=%0d exp=0", dbg_ctx[11:9]); end
        ctx_clear = '0;
        req_val   = 4'b1000;
        #1;
        total++; if (req_rdy !== 4'b1000) begin bad++; $display("FAIL clr_after_rdy got=%b exp=%b", req_rdy, 4'b1000); end
        tick();
        total++; if (resp_w !== {1'b1, 2'd3, 3'd1, 2'b00}) begin bad++; $display("FAIL clr_after got=%h exp=%h", resp_w, {1'b1, 2'd3, 3'd1, 2'b00}); end
        req_val = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_sequence_r0();
        test_ctx_independent();
        test_round_robin();
        test_back_pressure();
        test_async_reset();
`ifdef FSM_CTX_ARBITER_CLEAR_EN
        test_clear();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
